// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, ALU and mux
// select codes, data-processing commands and condition-code values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctl_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator: decides whether an instruction
// with condition field cond executes given the current NZCV flags.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_ex
);

  logic n, z, c, v;
  logic ge;

  assign {n, z, c, v} = nzcv;
  assign ge = (n == v);

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~(c & ~z);
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = ~ge;
      COND_GT: cond_ex = ~z & ge;
      COND_LE: cond_ex = ~(~z & ge);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM: sequences the shared-memory datapath, holds NZCV
// and gates writes by the condition latched in DECODE. Optional CMP: CTRL_NOWRITE_CMP_EN.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int         STATE_W  = 4,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [3:0]         Cond,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic [3:0]         Rd,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ResultSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUControl,
  output logic [STATE_W-1:0] State
);

  state_t   state, state_next;
  logic [3:0] flags;
  logic     cond_ex_now, cond_ex;
  alu_ctl_t alu_ctl_dec;
  logic     cmd_known, cmd_cmp, cmd_write;
  logic [1:0] flag_w;
  logic     ir_w, pc_fetch, reg_w, mem_w, branch, exec_st;
  logic     rd_pc;

  cond_check u_cond_check (
    .cond    (Cond),
    .nzcv    (flags),
    .cond_ex (cond_ex_now)
  );

  assign rd_pc  = (Rd == REG_PC);
  assign ImmSrc = Op;
  assign RegSrc = {(Op == OP_MEM), (Op == OP_BR)};
  assign State  = STATE_W'(state);

  // Reset wins over everything, so an aborted EXEC never updates flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_FETCH;
      flags   <= FLAG_RST;
      cond_ex <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) cond_ex <= cond_ex_now;
      if (exec_st && cond_ex) begin
        if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
        if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    alu_ctl_dec = ALU_ADD;
    cmd_known   = 1'b1;
    cmd_cmp     = 1'b0;
    case (Funct[4:1])
      CMD_ADD: alu_ctl_dec = ALU_ADD;
      CMD_SUB: alu_ctl_dec = ALU_SUB;
      CMD_AND: alu_ctl_dec = ALU_AND;
      CMD_ORR: alu_ctl_dec = ALU_ORR;
`ifdef CTRL_NOWRITE_CMP_EN
      CMD_CMP: begin
        alu_ctl_dec = ALU_SUB;
        cmd_cmp     = 1'b1;
      end
`endif
      default: cmd_known = 1'b0;
    endcase
  end

  // Unknown commands still run as ADD but must not write a register.
  assign cmd_write = cmd_known & ~cmd_cmp;
  assign flag_w[1] = Funct[0] | cmd_cmp;
  assign flag_w[0] = (Funct[0] & ((alu_ctl_dec == ALU_ADD) | (alu_ctl_dec == ALU_SUB))) | cmd_cmp;

  always_comb begin
    state_next = S_FETCH;
    ir_w       = 1'b0;
    pc_fetch   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    exec_st    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RD2;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;

    case (state)
      S_FETCH: begin
        state_next = S_DECODE;
        ir_w       = 1'b1;
        pc_fetch   = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (Op)
          OP_MEM:  state_next = S_MEMADR;
          OP_DP:   state_next = Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = SRCB_EXTIMM;
        state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc     = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcB    = SRCB_RD2;
        ALUControl = alu_ctl_dec;
        exec_st    = 1'b1;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB    = SRCB_EXTIMM;
        ALUControl = alu_ctl_dec;
        exec_st    = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        reg_w     = cmd_write;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_EXTIMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    // While in reset the datapath sees FETCH selects but no enables.
    if (RST) begin
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b1;
      ALUSrcB    = SRCB_FOUR;
      ResultSrc  = RES_ALURESULT;
      ALUControl = ALU_ADD;
    end

    IRWrite  = ~RST & ir_w;
    MemWrite = ~RST & mem_w & cond_ex;
    RegWrite = ~RST & reg_w & cond_ex & ~rd_pc;
    PCWrite  = ~RST & (pc_fetch | (branch & cond_ex) | (reg_w & cond_ex & rd_pc));
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level model pushes
// per-cycle expected outputs, a negedge monitor pops and compares them.
module tb_multicycle_controller;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0] State;

  multicycle_controller #(.STATE_W(4), .FLAG_RST(4'b0000)) dut (
    .CLK(CLK), .RST(RST), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] state;
    logic       pcw, memw, regw, irw, adrsrc;
    logic [1:0] ressrc;
    logic       srca;
    logic [1:0] srcb, aluctl, immsrc, regsrc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_exp, mon_act;
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] m_flags;

  // Monitor: one expected vector per cycle, sampled mid-cycle.
  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      mon_act = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};
      vectors++;
      if (mon_act !== mon_exp) begin
        miscompares++;
        $display("[TB] FAIL cycle_outputs vec %0d t=%0t: got %p required %p",
                 vectors, $time, mon_act, mon_exp);
      end
    end
  end

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !(cf && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Data-processing command meaning: ALU op, whether it writes Rd, CMP-ness.
  task automatic dp_meaning(input logic [3:0] cmd, output logic [1:0] ctl,
                            output bit wr_ok, output bit cmp);
    ctl = 2'b00; wr_ok = 1'b1; cmp = 1'b0;
    if (cmd == 4'b0100) ctl = 2'b00;
    else if (cmd == 4'b0010) ctl = 2'b01;
    else if (cmd == 4'b0000) ctl = 2'b10;
    else if (cmd == 4'b1100) ctl = 2'b11;
`ifdef CTRL_NOWRITE_CMP_EN
    else if (cmd == 4'b1010) begin ctl = 2'b01; wr_ok = 1'b0; cmp = 1'b1; end
`endif
    else wr_ok = 1'b0;
  endtask

  function automatic exp_t make_exp(input int st, input bit rst, input bit ce,
                                    input logic [1:0] op, input logic [1:0] ctl,
                                    input bit wr_ok, input logic [3:0] rd);
    exp_t e;
    e = '0;
    e.state  = 4'(st);
    e.immsrc = op;
    e.regsrc = {op == 2'b01, op == 2'b10};
    if (rst || st == 0) begin
      e.srca = 1'b1; e.srcb = 2'b10; e.ressrc = 2'b10;
      if (!rst) begin e.irw = 1'b1; e.pcw = 1'b1; end
      return e;
    end
    case (st)
      1: begin e.srca = 1'b1; e.srcb = 2'b10; e.ressrc = 2'b10; end
      2: e.srcb = 2'b01;
      3: e.adrsrc = 1'b1;
      4: begin e.ressrc = 2'b01; e.regw = ce && rd != 15; e.pcw = ce && rd == 15; end
      5: begin e.adrsrc = 1'b1; e.memw = ce; end
      6: e.aluctl = ctl;
      7: begin e.srcb = 2'b01; e.aluctl = ctl; end
      8: begin e.regw = ce && wr_ok && rd != 15; e.pcw = ce && wr_ok && rd == 15; end
      9: begin e.srcb = 2'b01; e.ressrc = 2'b10; e.pcw = ce; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic resetCycles(input int n);
    RST = 1'b1;
    for (int i = 0; i < n; i++) begin
      ALUFlags = 4'($urandom);
      sb_q.push_back(make_exp(0, 1'b1, 1'b0, Op, 2'b00, 1'b0, Rd));
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    m_flags = 4'b0000;
  endtask

  // One instruction from FETCH; reset_at >= 0 asserts RST on that step.
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                               input logic [3:0] cond, input logic [3:0] rd,
                               input logic [3:0] exec_flags, input int reset_at);
    int seq[$];
    bit ce, wr_ok, cmp, fw_nz, fw_cv;
    logic [1:0] ctl;
    seq = '{0, 1};
    case (op)
      2'b01:   seq = funct[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
      2'b00:   seq = funct[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
      2'b10:   seq = '{0, 1, 9};
      default: seq = '{0, 1};
    endcase
    dp_meaning(funct[4:1], ctl, wr_ok, cmp);
    fw_nz = funct[0] || cmp;
    fw_cv = (funct[0] && ctl inside {2'b00, 2'b01}) || cmp;
    ce = cond_holds(cond, m_flags);
    Op = op; Funct = funct; Cond = cond; Rd = rd;
    for (int k = 0; k < seq.size(); k++) begin
      bit is_exec;
      is_exec = (seq[k] == 6 || seq[k] == 7);
      ALUFlags = is_exec ? exec_flags : 4'($urandom);
      if (k == reset_at) begin
        RST = 1'b1;
        sb_q.push_back(make_exp(seq[k], 1'b1, ce, op, ctl, wr_ok, rd));
        @(posedge CLK); #1;
        RST = 1'b0;
        m_flags = 4'b0000;
        return;
      end
      sb_q.push_back(make_exp(seq[k], 1'b0, ce, op, ctl, wr_ok, rd));
      @(posedge CLK); #1;
      if (is_exec && ce) begin
        if (fw_nz) m_flags[3:2] = exec_flags[3:2];
        if (fw_cv) m_flags[1:0] = exec_flags[1:0];
      end
    end
  endtask

  task automatic checkOutput();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries required 0", sb_q.size());
    end
  endtask

  initial begin
    RST = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    m_flags = 4'b0000;
    @(posedge CLK); #1;
    resetCycles(3);

    applyStimulus(2'b01, 6'b011001, 4'hE, 4'd3, 4'h0, -1);  // LDR
    applyStimulus(2'b00, 6'b001001, 4'hE, 4'd2, 4'b0110, -1); // ADDS -> Z
    applyStimulus(2'b10, 6'b100000, 4'h0, 4'd0, 4'h0, -1);  // BEQ taken
    applyStimulus(2'b00, 6'b000101, 4'hE, 4'd2, 4'b1000, -1); // SUBS -> N
    applyStimulus(2'b10, 6'b100000, 4'h0, 4'd0, 4'h0, -1);  // BEQ not taken
    applyStimulus(2'b01, 6'b011000, 4'h1, 4'd5, 4'h0, -1);  // STRNE
    applyStimulus(2'b00, 6'b101000, 4'hE, 4'd15, 4'h0, -1); // ADD to PC
    applyStimulus(2'b11, 6'b000000, 4'hE, 4'd1, 4'h0, -1);  // undefined
    applyStimulus(2'b00, 6'b001001, 4'hE, 4'd2, 4'b0100, -1); // set Z before reset
    applyStimulus(2'b01, 6'b011000, 4'hE, 4'd5, 4'h0, 3);   // STR aborted in MEMWR
    applyStimulus(2'b10, 6'b100000, 4'h0, 4'd0, 4'h0, -1);  // BEQ: flags cleared
    applyStimulus(2'b10, 6'b100000, 4'h1, 4'd0, 4'h0, -1);  // BNE taken
    applyStimulus(2'b00, 6'b001100, 4'hE, 4'd4, 4'hF, -1);  // undefined cmd
    applyStimulus(2'b00, 6'b010100, 4'hE, 4'd4, 4'hF, -1);  // cmd 1010
    applyStimulus(2'b01, 6'b011001, 4'hF, 4'd15, 4'h0, -1); // never-condition LDR
    applyStimulus(2'b01, 6'b011001, 4'hE, 4'd15, 4'h0, -1); // LDR to PC
    applyStimulus(2'b00, 6'b001001, 4'hE, 4'd2, 4'hF, 2);   // ADDS aborted in EXEC
    applyStimulus(2'b10, 6'b100000, 4'h0, 4'd0, 4'h0, -1);  // flags must still be 0

    for (int i = 0; i < 300; i++) begin
      logic [1:0] op;
      logic [3:0] cmd;
      logic [5:0] funct;
      logic [3:0] rd;
      int rst_at;
      op = 2'($urandom_range(0, 3));
      funct = 6'($urandom);
      if (op == 2'b00) begin
        case ($urandom_range(0, 4))
          0: cmd = 4'b0100;
          1: cmd = 4'b0010;
          2: cmd = 4'b0000;
          3: cmd = 4'b1100;
          default: cmd = 4'($urandom);
        endcase
        funct[4:1] = cmd;
        if (!(cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100})) funct[0] = 1'b0;
      end
      rd = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom);
      rst_at = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 4)) : -1;
      applyStimulus(op, funct, 4'($urandom), rd, 4'($urandom), rst_at);
      if ($urandom_range(0, 49) == 0) resetCycles(int'($urandom_range(1, 2)));
    end

    @(negedge CLK); #1;
    checkOutput();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
